// File: rtl/lksum_disp_pkg.sv
// Shared definitions for the linked-list summer display stage.
// Contents:
//   conv_state_t        - binary-to-BCD converter states
//   SEG_0..SEG_9        - active-low {g,f,e,d,c,b,a} digit patterns
//   SEG_DASH, SEG_BLANK - overflow dash and unlit digit patterns
//   OVF_LIMIT           - first value that no longer fits in 8 decimal digits
//   seg_decode()        - BCD nibble to segment pattern
package lksum_disp_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    COMMIT
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [31:0] OVF_LIMIT = 32'd100_000_000;

  // Nibbles above 9 only arise from overflowed inputs, which are shown as
  // dashes anyway; they decode to blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/lksum_bin2bcd.sv
// Sequential double-dabble converter, free-running LOAD -> SHIFT x32 -> COMMIT.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   bin    in   32-bit unsigned value, sampled only in LOAD
//   bcd    out  8-digit BCD result; final while commit is high
//   ovf    out  bin >= OVF_LIMIT for the value being converted
//   commit out  one-cycle pulse, bcd/ovf hold the finished conversion
module lksum_bin2bcd
  import lksum_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bin,
  output logic [31:0] bcd,
  output logic        ovf,
  output logic        commit
);

  conv_state_t state, state_next;
  logic [31:0] shift_q;
  logic [4:0]  bit_cnt;
  logic [31:0] bcd_adj;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      LOAD:    state_next = SHIFT;
      SHIFT:   if (bit_cnt == 5'd31) state_next = COMMIT;
      COMMIT: begin
        state_next = LOAD;
        commit     = 1'b1;
      end
      default: state_next = LOAD;
    endcase
  end

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 8; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // NOTE: the datapath is reset as well; it is a handful of flops, and a
  // known value keeps an aborted conversion from leaking into the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      bcd     <= '0;
      ovf     <= 1'b0;
      bit_cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          shift_q <= bin;
          bcd     <= '0;
          ovf     <= (bin >= OVF_LIMIT);
          bit_cnt <= '0;
        end
        SHIFT: begin
          {bcd, shift_q} <= {bcd_adj, shift_q} << 1;
          bit_cnt        <= bit_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lksum_segdisp.sv
// 8-digit multiplexed seven-segment display of the summer result.
// Ports:
//   clk   in   board clock, rising edge
//   rst   in   synchronous active-high reset
//   value in   32-bit unsigned sum, may change any cycle
//   valid in   summation complete; lights the decimal point on digit 0
//   an    out  digit anodes, active-low one-hot, an[0] = rightmost
//   seg   out  segments {g,f,e,d,c,b,a}, active-low
//   dp    out  decimal point, active-low
module lksum_segdisp
  import lksum_disp_pkg::*;
#(
  parameter int SCAN_BITS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        valid,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic [SCAN_BITS+2:0] scan_cnt;
  logic [2:0]           digit;
  logic [31:0]          conv_bcd;
  logic                 conv_ovf;
  logic                 commit;
  logic [31:0]          disp_bcd;
  logic                 disp_ovf;
  logic [31:0]          upper;
  logic [6:0]           seg_next;

  lksum_bin2bcd u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .bin    (value),
    .bcd    (conv_bcd),
    .ovf    (conv_ovf),
    .commit (commit)
  );

  assign digit = scan_cnt[SCAN_BITS+2 -: 3];

  // Nibbles from the lit digit upward; all zero means a leading zero.
  always_comb begin
    upper = disp_bcd >> {digit, 2'b00};
    if (disp_ovf)                            seg_next = SEG_DASH;
    else if (digit != 3'd0 && upper == '0)   seg_next = SEG_BLANK;
    else                                     seg_next = seg_decode(upper[3:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
      an       <= 8'hFF;
      seg      <= SEG_BLANK;
      dp       <= 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (commit) begin
        disp_bcd <= conv_bcd;
        disp_ovf <= conv_ovf;
      end
      an  <= ~(8'd1 << digit);
      seg <= seg_next;
      dp  <= !(digit == 3'd0 && valid);
    end
  end

endmodule

// File: tb/tb_lksum_segdisp.sv
// Self-checking bench for lksum_segdisp with SCAN_BITS=2 (4 cycles/digit).
// Expected segments come from decimal arithmetic on the applied value.
module tb_lksum_segdisp;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic [31:0] value = '0;
  logic        valid = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;   // rising edges since reset was released

  lksum_segdisp #(.SCAN_BITS(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .valid (valid),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Segment pattern digit i should show for value v.
  function automatic logic [6:0] model_seg(input longint unsigned v, input int i);
    longint unsigned p;
    if (v >= 64'd100000000) return 7'h3F;
    p = v;
    for (int k = 0; k < i; k++) p = p / 10;
    if (i > 0 && p == 0) return 7'h7F;
    case (int'(p % 10))
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  // Output after edge n (n>=1) shows digit ((n-1)/4) mod 8.
  task automatic check_cycle(input string tag, input logic [31:0] v, input logic vld);
    int         d;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    d       = ((edges - 1) / 4) % 8;
    exp_an  = ~(8'd1 << d);
    exp_seg = model_seg({32'd0, v}, d);
    exp_dp  = !(d == 0 && vld);
    check({tag, ".an"},  {24'd0, an},   {24'd0, exp_an});
    check({tag, ".seg"}, {25'd0, seg},  {25'd0, exp_seg});
    check({tag, ".dp"},  {31'd0, dp},   {31'd0, exp_dp});
  endtask

  task automatic check_frame(input string tag, input logic [31:0] v, input logic vld, input int n);
    repeat (n) begin
      @(negedge clk);
      check_cycle(tag, v, vld);
    end
  endtask

  // Apply a value, allow the worst-case 68-cycle latency, then check a frame.
  task automatic apply(input string tag, input logic [31:0] v, input logic vld);
    value = v;
    valid = vld;
    repeat (67) @(negedge clk);
    check_frame(tag, v, vld, 32);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".an"},  {24'd0, an},  32'hFF);
    check({tag, ".seg"}, {25'd0, seg}, 32'h7F);
    check({tag, ".dp"},  {31'd0, dp},  32'h1);
  endtask

  initial begin
    logic [31:0] r;
    logic        rv;
    int          guard;

    // Reset for three cycles, idle display of 0.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    check_frame("idle0", 32'd0, 1'b0, 40);

    // Directed values and boundaries.
    apply("v12345678", 32'd12345678, 1'b1);
    apply("v1e8",      32'd100000000, 1'b1);
    apply("v99999999", 32'd99999999, 1'b0);
    apply("v305",      32'd305, 1'b1);
    apply("vzero",     32'd0, 1'b1);
    apply("vmax",      32'hFFFFFFFF, 1'b0);

    // Random values, mostly in displayable range.
    for (int i = 0; i < 6; i++) begin
      r  = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 99999999);
      rv = 1'($urandom_range(0, 1));
      apply("rand", r, rv);
    end

    // Reset in the middle of a conversion, 42 already on display.
    apply("v42", 32'd42, 1'b1);
    guard = 0;
    while (!(((edges - 1) % 34) inside {[5:20]}) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("shift_phase_found", guard < 100 ? 32'd1 : 32'd0, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    check_frame("rst_cleared", 32'd0, 1'b1, 34);
    check_frame("v42_again", 32'd42, 1'b1, 32);

    // Input change during SHIFT is ignored until the next LOAD.
    rst   = 1'b1;
    value = 32'd7;
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_frame("pre7", 32'd0, 1'b0, 11);   // now just after shift iteration 10
    value = 32'd9;
    check_frame("pre7b", 32'd0, 1'b0, 23);
    check_frame("hold7", 32'd7, 1'b0, 34);
    check_frame("show9", 32'd9, 1'b0, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
